duty_cycle_calc: RTL

- Downstream stage of the duty-cycle meter. Consumes one pair of per-window sig_in high/low sys_clk counts per measurement.
- Computes duty cycle as a fixed-point fraction, duty = high_cnt * SCALE / (high_cnt + low_cnt), using a sequential restoring divider (1 quotient bit per clock).
- Presents the result with a one-cycle valid strobe for the display/UART layer.

---
 rtl/duty_cycle_calc.sv | 139 +++++++++++++
 1 files changed

// File: rtl/duty_cycle_calc.sv
`timescale 1ns/1ps
// Purpose : duty = high_cnt*SCALE/(high_cnt+low_cnt) via a 1-bit/clock restoring divider.
// Latency : ITER cycles in DIV plus one DONE cycle; duty_valid pulses in the DONE cycle.
// Backpressure: none; cnt_valid while busy is dropped and latches the sticky overrun flag.
//
// Ports:
//   sys_clk, rst          clock, synchronous active-high reset
//   high_cnt, low_cnt     per-window high/low counts, qualified by cnt_valid
//   duty_cycle, div_zero  last result (0..SCALE) and zero-window flag, held until next result
//   duty_valid            one-cycle strobe when duty_cycle/div_zero update
//   busy                  request in flight (DIV or DONE)
//   overrun               sticky: request arrived while busy; cleared only by rst
// Build option: define DUTY_ROUND_EN to round to nearest (ties up) instead of truncating.
module duty_cycle_calc #(
   parameter int SCALE = 1000,
   parameter int ITER  = 64
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic [31:0] high_cnt,
   input  logic [31:0] low_cnt,
   input  logic        cnt_valid,
   output logic [15:0] duty_cycle,
   output logic        duty_valid,
   output logic        busy,
   output logic        div_zero,
   output logic        overrun
);

   localparam int CW = $clog2(ITER);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DIV  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   // Dividend shifts out MSB first; quotient bits shift in at the LSB, so after
   // ITER steps this register holds the full quotient.
   logic [63:0]   dividend;
   logic [32:0]   divisor;
   logic [32:0]   rem;
   logic [CW-1:0] iter_cnt;
   logic          zero_flag;

   // 33-bit sum keeps the carry so 0xFFFFFFFF + 0xFFFFFFFF does not wrap.
   logic [32:0] sum;
   logic [63:0] dividend_init;

   assign sum = {1'b0, high_cnt} + {1'b0, low_cnt};

   always_comb begin
      dividend_init = {32'b0, high_cnt} * 64'(SCALE);
`ifdef DUTY_ROUND_EN
      // Adding half the divisor before truncating rounds to nearest, ties up.
      dividend_init = dividend_init + {31'b0, sum[32:1]};
`endif
   end

   // One restoring step. rem < divisor always holds, so the shifted remainder
   // fits 34 bits and bit 33 of the difference is a clean borrow indicator.
   logic [33:0] rem_shift;
   logic [33:0] rem_diff;
   logic        q_bit;
   logic [32:0] rem_next;
   logic [63:0] quot_next;
   logic [15:0] result;

   assign rem_shift = {rem, dividend[63]};
   assign rem_diff  = rem_shift - {1'b0, divisor};
   assign q_bit     = ~rem_diff[33];
   assign rem_next  = q_bit ? rem_diff[32:0] : rem_shift[32:0];
   assign quot_next = {dividend[62:0], q_bit};

   // Quotient never exceeds SCALE mathematically; the clamp keeps the output
   // bounded even so, and a zero window always reports 0.
   always_comb begin
      result = quot_next[15:0];
      if (quot_next > 64'(SCALE)) begin
         result = 16'(SCALE);
      end
      if (zero_flag) begin
         result = 16'd0;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state      <= IDLE;
         dividend   <= '0;
         divisor    <= '0;
         rem        <= '0;
         iter_cnt   <= '0;
         zero_flag  <= 1'b0;
         duty_cycle <= 16'd0;
         duty_valid <= 1'b0;
         div_zero   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cnt_valid) begin
                  dividend  <= dividend_init;
                  divisor   <= sum;
                  rem       <= '0;
                  iter_cnt  <= CW'(ITER - 1);
                  zero_flag <= (sum == 33'd0);
                  state     <= DIV;
               end
            end
            DIV: begin
               dividend <= quot_next;
               rem      <= rem_next;
               iter_cnt <= iter_cnt - 1'b1;
               if (iter_cnt == '0) begin
                  // Final quotient bit is taken combinationally so the result
                  // lands together with the entry into DONE.
                  state      <= DONE;
                  duty_valid <= 1'b1;
                  duty_cycle <= result;
                  div_zero   <= zero_flag;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (cnt_valid && (state != IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule
